// File: rtl/rom_dl_pkg.sv
// Shared types and address-window constants for the ROM download controller.
package rom_dl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2,
        RUN  = 2'd3
    } dl_state_t;

    localparam logic [24:0] PROG_ROM_BASE = 25'h0000000;
    localparam logic [24:0] VEC_ROM_BASE  = 25'h0004000;
    localparam logic [24:0] VEC_ROM_END   = 25'h0005000;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [24:0] sat_inc(input logic [24:0] v);
        return (v == 25'h1FFFFFF) ? v : v + 25'd1;
    endfunction

endpackage

// File: rtl/dl_edge_detect.sv
// Rise/fall pulse generator built on a registered copy of a level input.
module dl_edge_detect #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise,
    output logic fall
);

    logic level_q;

    // Reset to RESET_VAL so a level still high after rst does not look like a new rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= RESET_VAL;
        end else begin
            level_q <= level;
        end
    end

    assign rise = level & ~level_q;
    assign fall = ~level & level_q;

endmodule

// File: rtl/rom_download_ctrl.sv
// Converts the HPS ioctl byte stream into the arcade top's dl_* ROM-load bus and
// holds the core in reset until a complete image is loaded. Optional: ROM_CHECKSUM_EN.
module rom_download_ctrl
    import rom_dl_pkg::*;
#(
    parameter logic [7:0]  ROM_INDEX   = 8'd0,
    parameter logic [24:0] ROM_SIZE    = VEC_ROM_END,
    parameter int          HOLD_CYCLES = 64
`ifdef ROM_CHECKSUM_EN
    ,
    parameter logic [15:0] EXPECTED_SUM = 16'h0000
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        ioctl_wr,
    output logic [24:0] dl_addr,
    output logic [7:0]  dl_data,
    output logic        dl_wr,
    output logic        core_run_l,
    output logic        loaded,
    output logic        short_err,
    output logic [24:0] byte_count
`ifdef ROM_CHECKSUM_EN
    ,
    output logic [15:0] rom_sum
`endif
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    dl_state_t     state_r;
    dl_state_t     next_s;
    logic [CW-1:0] hold_cnt_r;
    logic          dl_rise_s;
    logic          dl_fall_s;
    logic          index_match_s;
    logic          start_s;
    logic          accept_s;
    logic          sum_ok_s;
    logic          image_ok_s;
    logic          enter_load_s;

    dl_edge_detect #(
        .RESET_VAL (1'b1)
    ) u_dl_edge (
        .clk   (clk),
        .rst   (rst),
        .level (ioctl_download),
        .rise  (dl_rise_s),
        .fall  (dl_fall_s)
    );

    assign index_match_s = (ioctl_index == ROM_INDEX);
    assign start_s       = dl_rise_s & index_match_s;
    assign accept_s      = (state_r == LOAD) & ioctl_download & ioctl_wr
                         & index_match_s & (ioctl_addr < ROM_SIZE);
    assign enter_load_s  = (next_s == LOAD) && (state_r != LOAD);

`ifdef ROM_CHECKSUM_EN
    assign sum_ok_s = (EXPECTED_SUM == 16'h0000) || (rom_sum == EXPECTED_SUM);
`else
    assign sum_ok_s = 1'b1;
`endif

    assign image_ok_s = (byte_count >= ROM_SIZE) && sum_ok_s;

    // Next-state decode; a matching start always wins from IDLE, HOLD and RUN.
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) next_s = LOAD;
                else         next_s = IDLE;
            end
            LOAD: begin
                if (dl_fall_s) next_s = image_ok_s ? HOLD : IDLE;
                else           next_s = LOAD;
            end
            HOLD: begin
                if (start_s)                   next_s = LOAD;
                else if (hold_cnt_r == CW'(0)) next_s = RUN;
                else                           next_s = HOLD;
            end
            RUN: begin
                if (start_s) next_s = LOAD;
                else         next_s = RUN;
            end
            default: next_s = IDLE;
        endcase
    end

    // State, hold counter and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            hold_cnt_r <= CW'(0);
            core_run_l <= 1'b0;
            loaded     <= 1'b0;
            short_err  <= 1'b0;
        end else begin
            state_r    <= next_s;
            core_run_l <= (next_s == RUN);
            if (state_r == LOAD && next_s == HOLD) begin
                hold_cnt_r <= CW'(HOLD_CYCLES - 1);
            end else if (state_r == HOLD && hold_cnt_r != CW'(0)) begin
                hold_cnt_r <= hold_cnt_r - CW'(1);
            end else begin
                hold_cnt_r <= hold_cnt_r;
            end
            if (enter_load_s) begin
                loaded <= 1'b0;
            end else if (state_r == HOLD && next_s == RUN) begin
                loaded <= 1'b1;
            end else begin
                loaded <= loaded;
            end
            if (state_r == LOAD && dl_fall_s && !image_ok_s) begin
                short_err <= 1'b1;
            end else if (state_r == HOLD && next_s == RUN) begin
                short_err <= 1'b0;
            end else begin
                short_err <= short_err;
            end
        end
    end

    // Registered ROM-load bus and accepted-byte counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            dl_addr    <= 25'd0;
            dl_data    <= 8'd0;
            dl_wr      <= 1'b0;
            byte_count <= 25'd0;
        end else begin
            dl_wr <= accept_s;
            if (accept_s) begin
                dl_addr <= ioctl_addr;
                dl_data <= ioctl_dout;
            end else begin
                dl_addr <= dl_addr;
                dl_data <= dl_data;
            end
            if (enter_load_s) begin
                byte_count <= 25'd0;
            end else if (accept_s) begin
                byte_count <= sat_inc(byte_count);
            end else begin
                byte_count <= byte_count;
            end
        end
    end

`ifdef ROM_CHECKSUM_EN
    // Running modulo-2^16 sum of accepted bytes, restarted with each download.
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_sum <= 16'h0000;
        end else if (enter_load_s) begin
            rom_sum <= 16'h0000;
        end else if (accept_s) begin
            rom_sum <= rom_sum + {8'h00, ioctl_dout};
        end else begin
            rom_sum <= rom_sum;
        end
    end
`endif

endmodule

// File: tb/tb_rom_download_ctrl.sv
// Directed, scoreboard-based bench for rom_download_ctrl (both ROM_CHECKSUM_EN builds).
module tb_rom_download_ctrl;

    localparam int HOLD = 64;
`ifdef ROM_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic [24:0] ioctl_addr = 25'd0;
    logic [7:0]  ioctl_dout = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] dl_addr;
    logic [7:0]  dl_data;
    logic        dl_wr;
    logic        core_run_l;
    logic        loaded;
    logic        short_err;
    logic [24:0] byte_count;
`ifdef ROM_CHECKSUM_EN
    logic [15:0] rom_sum;
`endif

    int errors = 0;
    int checks = 0;
    logic [32:0] sb[$];

    always #5 clk = ~clk;

    rom_download_ctrl #(
        .ROM_INDEX   (8'd0),
        .ROM_SIZE    (25'h0005000),
        .HOLD_CYCLES (HOLD)
`ifdef ROM_CHECKSUM_EN
        ,
        .EXPECTED_SUM (16'h1234)
`endif
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wr       (ioctl_wr),
        .dl_addr        (dl_addr),
        .dl_data        (dl_data),
        .dl_wr          (dl_wr),
        .core_run_l     (core_run_l),
        .loaded         (loaded),
        .short_err      (short_err),
        .byte_count     (byte_count)
`ifdef ROM_CHECKSUM_EN
        ,
        .rom_sum        (rom_sum)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Every accepted strobe must show up on dl_* exactly one edge later.
    task automatic monitor();
        logic [32:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("dl_wr", {31'd0, dl_wr}, 32'd1);
                chk("dl_addr", {7'd0, dl_addr}, {7'd0, e[32:8]});
                chk("dl_data", {24'd0, dl_data}, {24'd0, e[7:0]});
            end else if (dl_wr !== 1'b0) begin
                chk("dl_wr_spurious", {31'd0, dl_wr}, 32'd0);
            end
        end
    endtask

    task automatic begin_dl(input logic [7:0] idx);
        @(negedge clk);
        ioctl_index    = idx;
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b1;
    endtask

    task automatic end_dl();
        @(negedge clk);
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
    endtask

    task automatic strobe(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d, input bit exp_acc);
        @(negedge clk);
        ioctl_index = idx;
        ioctl_addr  = a;
        ioctl_dout  = d;
        ioctl_wr    = 1'b1;
        if (exp_acc) sb.push_back({a, d});
    endtask

    // Index-0 image of nbytes; tail shapes the last 256 bytes so the sum is 16'h1234.
    task automatic load_image(input int nbytes, input bit tail, input bit bump);
        int sum;
        int need;
        logic [7:0] d;
        sum  = 0;
        need = 0;
        begin_dl(8'd0);
        for (int n = 0; n < nbytes; n++) begin
            d = n[7:0];
            if (tail && n >= 32'h4F00) begin
                if (n == 32'h4F00) need = (32'h1234 - sum) & 32'hFFFF;
                d = (need > 255) ? 8'hFF : 8'(need);
                need = need - int'(d);
            end
            if (bump && n == nbytes - 1) d = d + 8'd1;
            sum = sum + int'(d);
            strobe(8'd0, 25'(n), d, 1'b1);
        end
        end_dl();
    endtask

    task automatic expect_hold(input logic [24:0] count);
        for (int i = 0; i <= HOLD; i++) begin
            @(posedge clk);
            #1;
            chk("hold_core_run_l", {31'd0, core_run_l}, (i == HOLD) ? 32'd1 : 32'd0);
        end
        chk("run_loaded", {31'd0, loaded}, 32'd1);
        chk("run_short_err", {31'd0, short_err}, 32'd0);
        chk("run_byte_count", {7'd0, byte_count}, {7'd0, count});
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_dl_addr"}, {7'd0, dl_addr}, 32'd0);
        chk({tag, "_dl_data"}, {24'd0, dl_data}, 32'd0);
        chk({tag, "_dl_wr"}, {31'd0, dl_wr}, 32'd0);
        chk({tag, "_core_run_l"}, {31'd0, core_run_l}, 32'd0);
        chk({tag, "_loaded"}, {31'd0, loaded}, 32'd0);
        chk({tag, "_short_err"}, {31'd0, short_err}, 32'd0);
        chk({tag, "_byte_count"}, {7'd0, byte_count}, 32'd0);
    endtask

    initial begin
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("idle_dl_wr", {31'd0, dl_wr}, 32'd0);
            chk("idle_core_run_l", {31'd0, core_run_l}, 32'd0);
        end
        chk("idle_loaded", {31'd0, loaded}, 32'd0);

        // Full image, back to back.
        load_image(32'h5000, CSUM, 1'b0);
        expect_hold(25'h0005000);
`ifdef ROM_CHECKSUM_EN
        chk("rom_sum_good", {16'd0, rom_sum}, 32'h1234);
`endif

        // Wrong-index download while running.
        begin_dl(8'd1);
        for (int n = 0; n < 100; n++) strobe(8'd1, 25'(n), n[7:0], 1'b0);
        end_dl();
        repeat (5) @(posedge clk);
        #1;
        chk("idx1_core_run_l", {31'd0, core_run_l}, 32'd1);
        chk("idx1_loaded", {31'd0, loaded}, 32'd1);

        // Matching start from RUN; addresses past the window are dropped.
        begin_dl(8'd0);
        @(posedge clk);
        #1;
        chk("restart_core_run_l", {31'd0, core_run_l}, 32'd0);
        chk("restart_loaded", {31'd0, loaded}, 32'd0);
        for (int a = 32'h4F00; a < 32'h5100; a++) strobe(8'd0, 25'(a), a[7:0], a < 32'h5000);
        end_dl();
        @(posedge clk);
        #1;
        chk("window_byte_count", {7'd0, byte_count}, 32'd256);
        chk("window_short_err", {31'd0, short_err}, 32'd1);

        // Short image.
        load_image(32'h3000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("short_short_err", {31'd0, short_err}, 32'd1);
        chk("short_byte_count", {7'd0, byte_count}, 32'h3000);
        repeat (HOLD + 4) @(posedge clk);
        #1;
        chk("short_core_run_l", {31'd0, core_run_l}, 32'd0);
        chk("short_loaded", {31'd0, loaded}, 32'd0);

        // rst in the middle of a download.
        begin_dl(8'd0);
        for (int n = 0; n < 32'h100; n++) strobe(8'd0, 25'(n), n[7:0], 1'b1);
        strobe(8'd0, 25'h100, 8'h00, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_values("midrst");
        @(negedge clk);
        rst = 1'b0;
        for (int n = 32'h101; n < 32'h200; n++) strobe(8'd0, 25'(n), n[7:0], 1'b0);
        end_dl();
        repeat (4) @(posedge clk);
        #1;
        chk("postrst_core_run_l", {31'd0, core_run_l}, 32'd0);
        chk("postrst_byte_count", {7'd0, byte_count}, 32'd0);
        chk("postrst_short_err", {31'd0, short_err}, 32'd0);

`ifdef ROM_CHECKSUM_EN
        load_image(32'h5000, 1'b1, 1'b0);
        expect_hold(25'h0005000);
        load_image(32'h5000, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        chk("badsum_short_err", {31'd0, short_err}, 32'd1);
        chk("badsum_rom_sum", {16'd0, rom_sum}, 32'h1235);
        repeat (HOLD + 4) @(posedge clk);
        #1;
        chk("badsum_core_run_l", {31'd0, core_run_l}, 32'd0);
        chk("badsum_loaded", {31'd0, loaded}, 32'd0);
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
